// File: rtl/butterfly_param.sv
// butterfly_param: pipelined modular NTT butterfly (GS/CT/ADDSUB/MUL) with valid/ready flow control
module butterfly_param #(
  parameter int DW      = 12,
  parameter int Q       = 3329,
  parameter int MUL_LAT = 2,
  parameter int GS_HALF = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_mode,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [DW-1:0] W,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] E,
  output logic [DW-1:0] O,
  output logic [1:0]    out_mode
);
  localparam logic [DW:0]     QE   = (DW+1)'(Q);
  localparam logic [2*DW-1:0] QP   = (2*DW)'(Q);
  localparam logic [1:0]      M_GS = 2'b00;
  localparam logic [1:0]      M_CT = 2'b01;
  localparam logic [1:0]      M_AS = 2'b10;

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    s = {1'b0, x} + {1'b0, y};
    return (s >= QE) ? DW'(s - QE) : DW'(s);
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y);
    return (x >= y) ? x - y : DW'({1'b0, x} + QE - {1'b0, y});
  endfunction

  // odd values borrow one Q so the shift divides exactly
  function automatic logic [DW-1:0] mod_half(input logic [DW-1:0] x);
    logic [DW:0] h;
    h = x[0] ? {1'b0, x} + QE : {1'b0, x};
    return DW'(h >> 1);
  endfunction

  logic          en;
  logic          v0;
  logic [1:0]    m0;
  logic [DW-1:0] a0, s0, d0, x0, y0;
  logic [2*DW-1:0] prod;
  logic          vp [MUL_LAT];
  logic [1:0]    mp [MUL_LAT];
  logic [DW-1:0] ap [MUL_LAT];
  logic [DW-1:0] sp [MUL_LAT];
  logic [DW-1:0] dp [MUL_LAT];
  logic [DW-1:0] tp [MUL_LAT];
  logic [DW-1:0] e_n, o_n;

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign prod     = {{DW{1'b0}}, x0} * {{DW{1'b0}}, y0};

  // operand stage: sums/differences and multiplier operand selection (GS multiplies the difference)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v0 <= 1'b0;
      m0 <= '0;
      a0 <= '0;
      s0 <= '0;
      d0 <= '0;
      x0 <= '0;
      y0 <= '0;
    end else if (en) begin
      v0 <= in_valid;
      m0 <= in_mode;
      a0 <= A;
      s0 <= mod_add(A, B);
      d0 <= mod_sub(A, B);
      x0 <= (in_mode == M_GS) ? mod_sub(A, B) : B;
      y0 <= W;
    end

  // multiplier stages: full product reduced in the first, side-band values carried alongside
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        vp[i] <= 1'b0;
        mp[i] <= '0;
        ap[i] <= '0;
        sp[i] <= '0;
        dp[i] <= '0;
        tp[i] <= '0;
      end
    end else if (en) begin
      vp[0] <= v0;
      mp[0] <= m0;
      ap[0] <= a0;
      sp[0] <= s0;
      dp[0] <= d0;
      tp[0] <= DW'(prod % QP);
      for (int i = 1; i < MUL_LAT; i++) begin
        vp[i] <= vp[i-1];
        mp[i] <= mp[i-1];
        ap[i] <= ap[i-1];
        sp[i] <= sp[i-1];
        dp[i] <= dp[i-1];
        tp[i] <= tp[i-1];
      end
    end

  // final combine per mode
  always_comb begin
    e_n = (mp[MUL_LAT-1] == M_CT) ? mod_add(ap[MUL_LAT-1], tp[MUL_LAT-1]) :
          (mp[MUL_LAT-1] == M_GS) ? ((GS_HALF != 0) ? mod_half(sp[MUL_LAT-1]) : sp[MUL_LAT-1]) :
          (mp[MUL_LAT-1] == M_AS) ? sp[MUL_LAT-1] : tp[MUL_LAT-1];
    o_n = (mp[MUL_LAT-1] == M_CT) ? mod_sub(ap[MUL_LAT-1], tp[MUL_LAT-1]) :
          (mp[MUL_LAT-1] == M_GS) ? ((GS_HALF != 0) ? mod_half(tp[MUL_LAT-1]) : tp[MUL_LAT-1]) :
          (mp[MUL_LAT-1] == M_AS) ? dp[MUL_LAT-1] : '0;
  end

  // output register, held while the consumer stalls
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_mode  <= '0;
      E         <= '0;
      O         <= '0;
    end else if (en) begin
      out_valid <= vp[MUL_LAT-1];
      out_mode  <= mp[MUL_LAT-1];
      E         <= e_n;
      O         <= o_n;
    end
endmodule
